// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths, register-0 index and the write-back entry type for the register write side.
package reg_writeback_unit_pkg;

    localparam int unsigned AddrW   = 5;
    localparam int unsigned DataW   = 32;
    localparam int unsigned ZeroReg = 0;

    typedef struct packed {
        logic [AddrW-1:0] rd;
        logic [DataW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_wb_fifo.sv
// In-order circular buffer of pending register writes, with an oldest-first view of every
// entry so the top level can run hazard compares against all of them in parallel.
module reg_writeback_unit_wb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    localparam int unsigned CntW  = $clog2(DEPTH + 1),
    localparam int unsigned PtrW  = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_rd_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [ADDR_W-1:0]        head_rd_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [CntW-1:0]          count_o,
    output logic [DEPTH-1:0]         ent_valid_o,
    output logic [DEPTH*ADDR_W-1:0]  ent_rd_o,
    output logic [DEPTH*DATA_W-1:0]  ent_data_o
);

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only observable while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            rd_mem_q[wr_ptr_q]   <= push_rd_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_rd_o   = rd_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = cnt_q;

    // Slot k of the view is the k-th oldest entry.
    always_comb begin
        logic [PtrW-1:0] idx;
        ent_valid_o = '0;
        ent_rd_o    = '0;
        ent_data_o  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PtrW'(k);
            ent_valid_o[k]                 = CntW'(k) < cnt_q;
            ent_rd_o[k*ADDR_W +: ADDR_W]   = rd_mem_q[idx];
            ent_data_o[k*DATA_W +: DATA_W] = data_mem_q[idx];
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register file write side: arbitrates ALU/memory write-backs into a FIFO, drains one write
// per cycle to the write port and reports youngest-match hazards for the two read ports.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DATA_W      = DataW,
    parameter int unsigned ADDR_W      = AddrW,
    parameter bit          ZERO_REG_RO = 1'b1,
    localparam int unsigned CntW       = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              WriteEnable,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              hazA,
    output logic              hazB,
    output logic [DATA_W-1:0] fwdA,
    output logic [DATA_W-1:0] fwdB,
    output logic [CntW-1:0]   count
);

    logic                    full, pop, push, mem_fire, alu_fire, discard;
    logic [ADDR_W-1:0]       in_rd, head_rd;
    logic [DATA_W-1:0]       in_data, head_data;
    logic [CntW-1:0]         cnt;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH*ADDR_W-1:0] ent_rd;
    logic [DEPTH*DATA_W-1:0] ent_data;
    logic                    we_q;
    logic [ADDR_W-1:0]       rw_q;
    logic [DATA_W-1:0]       busw_q;

    // Readiness ignores a same-cycle pop so the ready path never depends on the drain.
    assign full      = cnt == CntW'(DEPTH);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign in_rd     = mem_fire ? mem_rd : alu_rd;
    assign in_data   = mem_fire ? mem_data : alu_data;
    assign discard   = ZERO_REG_RO && (in_rd == ADDR_W'(ZeroReg));
    assign push      = (mem_fire || alu_fire) && !discard;
    assign pop       = cnt != '0;

    reg_writeback_unit_wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_rd_i   (in_rd),
        .push_data_i (in_data),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .count_o     (cnt),
        .ent_valid_o (ent_valid),
        .ent_rd_o    (ent_rd),
        .ent_data_o  (ent_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q   <= 1'b0;
            rw_q   <= '0;
            busw_q <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                rw_q   <= head_rd;
                busw_q <= head_data;
            end
        end
    end

    assign WriteEnable = we_q;
    assign RW          = rw_q;
    assign BusW        = busw_q;
    assign count       = cnt;

    // Output stage is oldest; scanning FIFO slots oldest-first lets the youngest match win.
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        fwdA = '0;
        fwdB = '0;
        if (we_q && rw_q == RA) begin
            hazA = 1'b1;
            fwdA = busw_q;
        end
        if (we_q && rw_q == RB) begin
            hazB = 1'b1;
            fwdB = busw_q;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent_rd[k*ADDR_W +: ADDR_W] == RA) begin
                hazA = 1'b1;
                fwdA = ent_data[k*DATA_W +: DATA_W];
            end
            if (ent_valid[k] && ent_rd[k*ADDR_W +: ADDR_W] == RB) begin
                hazB = 1'b1;
                fwdB = ent_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench: a queue-based reference of the write side checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    localparam int unsigned Depth = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_rd, alu_rd, ra, rb;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, we, haz_a, haz_b;
    logic [4:0]  rw;
    logic [31:0] busw, fwd_a, fwd_b;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    bit model_on = 1'b0;

    // Reference state: pending writes oldest-first plus the write-port stage.
    wb_entry_t   q[$];
    logic        m_we;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;

    reg_writeback_unit dut (
        .clock       (clock),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .RW          (rw),
        .BusW        (busw),
        .WriteEnable (we),
        .RA          (ra),
        .RB          (rb),
        .hazA        (haz_a),
        .hazB        (haz_b),
        .fwdA        (fwd_a),
        .fwdB        (fwd_b),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_haz(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (q[i].rd == a) begin
                h = 1'b1;
                d = q[i].data;
                break;
            end
        end
        if (!h && m_we && m_rw == a) begin
            h = 1'b1;
            d = m_busw;
        end
    endtask

    // Waits to the falling edge and compares every output against the reference.
    task automatic sample();
        logic        h;
        logic [31:0] d;
        @(negedge clock);
        if (model_on) begin
            chk("mem_ready", 32'(mem_ready), 32'(q.size() < Depth));
            chk("alu_ready", 32'(alu_ready), 32'(q.size() < Depth && !mem_valid));
            chk("WriteEnable", 32'(we), 32'(m_we));
            chk("RW", 32'(rw), 32'(m_rw));
            chk("BusW", busw, m_busw);
            chk("count", 32'(count), 32'(q.size()));
            model_haz(ra, h, d);
            chk("hazA", 32'(haz_a), 32'(h));
            chk("fwdA", fwd_a, d);
            model_haz(rb, h, d);
            chk("hazB", 32'(haz_b), 32'(h));
            chk("fwdB", fwd_b, d);
        end
    endtask

    // Advances the reference across the next rising edge, then waits past it.
    task automatic step(output bit mf, output bit af);
        wb_entry_t e;
        bit        has_room;
        has_room = q.size() < Depth;
        mf = mem_valid && has_room;
        af = alu_valid && !mem_valid && has_room;
        if (reset) begin
            q.delete();
            m_we   = 1'b0;
            m_rw   = '0;
            m_busw = '0;
        end else begin
            if (q.size() > 0) begin
                e      = q.pop_front();
                m_we   = 1'b1;
                m_rw   = e.rd;
                m_busw = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (mf || af) begin
                e.rd   = mf ? mem_rd : alu_rd;
                e.data = mf ? mem_data : alu_data;
                if (e.rd != 5'd0) q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cyc();
        bit mf, af;
        sample();
        step(mf, af);
    endtask

    initial begin
        bit mf, af;
        reset = 1'b1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
        ra = '0; rb = '0;
        m_we = 1'b0; m_rw = '0; m_busw = '0;
        step(mf, af);
        step(mf, af);
        model_on = 1'b1;
        reset = 1'b0;

        // Reset state
        sample();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_busw", busw, 32'd0);
        step(mf, af);

        // Single write: visible on the port two cycles after acceptance, for one cycle
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF; ra = 5'd7; rb = 5'd9;
        sample();
        chk("single_ready", 32'(alu_ready), 32'd1);
        step(mf, af);
        alu_valid = 1'b0;
        sample();
        chk("single_cnt1", 32'(count), 32'd1);
        chk("single_we0", 32'(we), 32'd0);
        chk("single_hazA", 32'(haz_a), 32'd1);
        chk("single_fwdA", fwd_a, 32'hDEADBEEF);
        step(mf, af);
        sample();
        chk("single_we1", 32'(we), 32'd1);
        chk("single_rw", 32'(rw), 32'd7);
        chk("single_busw", busw, 32'hDEADBEEF);
        chk("single_cnt0", 32'(count), 32'd0);
        step(mf, af);
        sample();
        chk("single_we_off", 32'(we), 32'd0);
        step(mf, af);

        // Priority: memory wins, then the ALU request follows one cycle behind
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        sample();
        chk("prio_mem_ready", 32'(mem_ready), 32'd1);
        chk("prio_alu_ready", 32'(alu_ready), 32'd0);
        step(mf, af);
        mem_valid = 1'b0;
        cyc();
        alu_valid = 1'b0;
        sample();
        chk("prio_rw_first", 32'(rw), 32'd3);
        step(mf, af);
        sample();
        chk("prio_rw_second", 32'(rw), 32'd4);
        chk("prio_busw_second", busw, 32'h22);
        step(mf, af);
        cyc();

        // Forwarding: youngest pending write to r5 wins
        ra = 5'd5; rb = 5'd6;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA;
        cyc();
        alu_data = 32'hB;
        cyc();
        alu_valid = 1'b0;
        sample();
        chk("fwd_hazA", 32'(haz_a), 32'd1);
        chk("fwd_fwdA", fwd_a, 32'hB);
        chk("fwd_hazB", 32'(haz_b), 32'd0);
        chk("fwd_fwdB", fwd_b, 32'd0);
        step(mf, af);
        sample();
        chk("fwd_out_hazA", 32'(haz_a), 32'd1);
        chk("fwd_out_fwdA", fwd_a, 32'hB);
        step(mf, af);
        sample();
        chk("fwd_clear_hazA", 32'(haz_a), 32'd0);
        step(mf, af);

        // Register 0 writes are accepted and dropped
        ra = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
        sample();
        chk("r0_ready", 32'(alu_ready), 32'd1);
        step(mf, af);
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("r0_count", 32'(count), 32'd0);
            chk("r0_we", 32'(we), 32'd0);
            chk("r0_hazA", 32'(haz_a), 32'd0);
            step(mf, af);
        end

        // Reset mid-operation discards pending work
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        ra = 5'd9; rb = 5'd10;
        cyc();
        mem_valid = 1'b0;
        cyc();
        alu_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("mid_rst_count", 32'(count), 32'd0);
            chk("mid_rst_we", 32'(we), 32'd0);
            chk("mid_rst_rw", 32'(rw), 32'd0);
            chk("mid_rst_busw", busw, 32'd0);
            chk("mid_rst_haz", 32'({haz_a, haz_b}), 32'd0);
            step(mf, af);
        end

        // Randomized requesters holding rd/data until accepted
        for (int n = 0; n < 600; n++) begin
            sample();
            step(mf, af);
            if (mf || !mem_valid) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd    = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            if (af || !alu_valid) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            ra    = 5'($urandom_range(0, 7));
            rb    = 5'($urandom_range(0, 7));
            reset = $urandom_range(0, 59) == 0;
        end
        reset = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
